// File: rtl/con_in_filter_if.sv
// Connector input filter bus: raw pins and enable in, filtered pins and change strobe out.
interface con_in_filter_if;
  logic       enable;
  logic [8:0] io_in;
  logic [5:0] io_out;
  logic       io678_out;
  logic       chg_pulse;
  logic [8:0] chg_mask;

  modport master (
    output enable, io_in,
    input  io_out, io678_out, chg_pulse, chg_mask
  );

  modport slave (
    input  enable, io_in,
    output io_out, io678_out, chg_pulse, chg_mask
  );
endinterface

// File: rtl/con_in_filter.sv
// 9-channel connector debounce: 2-flop sync, then filt follows after STABLE_CNT differing cycles.
// Change strobe/mask built only with CON_IN_FILTER_CHG_EN defined; otherwise tied to 0.
module con_in_filter #(
  parameter int STABLE_CNT = 16,
  parameter int CNT_W      = 8
) (
  input logic           CLK,
  input logic           RST_N,
  con_in_filter_if.slave bus
);
  localparam int                 NCH     = 9;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic [NCH-1:0]   sync1_q, sync2_q;
  logic [NCH-1:0]   filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      // Disabled: counters stay cleared so counting restarts from 0 on re-enable.
      if (bus.enable && (sync2_q[i] != filt_q[i])) begin
        if (cnt_q[i] == CNT_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= bus.io_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.io_out    = filt_q[5:0];
  assign bus.io678_out = |filt_q[8:6];

`ifdef CON_IN_FILTER_CHG_EN
  logic [NCH-1:0] prev_q, prev_d;
  logic [NCH-1:0] chg_mask_q, chg_mask_d;
  logic           chg_pulse_q, chg_pulse_d;

  // prev_q lags filt_q by one edge, so the strobe lands one cycle after the change.
  always_comb begin
    prev_d      = filt_q;
    chg_mask_d  = filt_q ^ prev_q;
    chg_pulse_d = |chg_mask_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_q      <= '0;
      chg_mask_q  <= '0;
      chg_pulse_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      chg_mask_q  <= chg_mask_d;
      chg_pulse_q <= chg_pulse_d;
    end
  end

  assign bus.chg_pulse = chg_pulse_q;
  assign bus.chg_mask  = chg_mask_q;
`else
  assign bus.chg_pulse = 1'b0;
  assign bus.chg_mask  = '0;
`endif
endmodule

// File: tb/tb_con_in_filter.sv
// Bench for con_in_filter: directed latency scenarios plus random stimulus against a run-length model.
module tb_con_in_filter;
  localparam int S = 16;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  con_in_filter_if bus ();

  con_in_filter #(.STABLE_CNT(S), .CNT_W(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: raw pins delayed two edges, then a channel flips once its synced value
  // has disagreed with the filtered value for S consecutive enabled edges.
  logic [8:0] m_s1, m_s2, m_filt;
  logic [8:0] m_last_change;   // change produced by the most recent edge
  logic [8:0] m_chg;           // change visible on the strobe outputs now
  int         m_run [9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_filt = '0; m_last_change = '0; m_chg = '0;
    for (int i = 0; i < 9; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [8:0] old_filt;
    if (!RST_N) begin
      model_clear();
    end else begin
      old_filt = m_filt;
      for (int i = 0; i < 9; i++) begin
        if (bus.enable && (m_s2[i] != m_filt[i])) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == S) begin
            m_filt[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_chg         = m_last_change;
      m_last_change = m_filt ^ old_filt;
      m_s2          = m_s1;
      m_s1          = bus.io_in;
    end
  endtask

  task automatic check_outs();
    chk("io_out", 32'(bus.io_out), 32'(m_filt[5:0]));
    chk("io678_out", 32'(bus.io678_out), 32'(|m_filt[8:6]));
`ifdef CON_IN_FILTER_CHG_EN
    chk("chg_pulse", 32'(bus.chg_pulse), 32'(|m_chg));
    chk("chg_mask", 32'(bus.chg_mask), 32'(m_chg));
`else
    chk("chg_pulse_tied", 32'(bus.chg_pulse), 32'(0));
    chk("chg_mask_tied", 32'(bus.chg_mask), 32'(0));
`endif
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  int         pulses_seen;
  logic [8:0] mask_or;
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outs();
    if (bus.chg_pulse) begin
      pulses_seen++;
      mask_or |= bus.chg_mask;
    end
  endtask

  task automatic apply_reset(input int len);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    model_clear();
    chk("rst_io_out", 32'(bus.io_out), 32'(0));
    chk("rst_io678", 32'(bus.io678_out), 32'(0));
    chk("rst_chg_pulse", 32'(bus.chg_pulse), 32'(0));
    chk("rst_chg_mask", 32'(bus.chg_mask), 32'(0));
    repeat (len) cycle();
    RST_N = 1'b1;
  endtask

  // Edges until io_out/io678 match target, counting from the first edge after the call.
  task automatic edges_until(input logic [5:0] lo, input logic hi, input int limit, output int edges);
    edges = -1;
    for (int k = 1; k <= limit; k++) begin
      cycle();
      if (bus.io_out == lo && bus.io678_out == hi) begin
        edges = k;
        break;
      end
    end
  endtask

  int e;
  int first_pulse;

  initial begin
    bus.enable = 1'b1;
    bus.io_in  = '0;
    model_clear();
    apply_reset(3);

    // Single step on IO0: 18 edges to output, strobe one edge later.
    @(negedge CLK);
    bus.io_in = 9'h001;
    pulses_seen = 0; mask_or = '0;
    edges_until(6'h01, 1'b0, 40, e);
    chk("step_latency", 32'(e), 32'(18));
    cycle();
`ifdef CON_IN_FILTER_CHG_EN
    chk("step_pulse_count", 32'(pulses_seen), 32'(1));
    chk("step_pulse_mask", 32'(mask_or), 32'h001);
`else
    chk("step_no_pulse", 32'(pulses_seen), 32'(0));
`endif
    repeat (5) cycle();

    // Short glitch on IO3 must not pass.
    apply_reset(2);
    @(negedge CLK);
    bus.io_in = 9'h008;
    pulses_seen = 0;
    repeat (10) cycle();
    bus.io_in = 9'h000;
    repeat (30) cycle();
    chk("glitch_io_out", 32'(bus.io_out), 32'(0));
    chk("glitch_pulses", 32'(pulses_seen), 32'(0));

    // IO6..8 together, then only IO7 drops.
    bus.io_in = 9'h1C0;
    pulses_seen = 0; mask_or = '0;
    edges_until(6'h00, 1'b1, 40, e);
    chk("grp_latency", 32'(e), 32'(18));
    repeat (3) cycle();
`ifdef CON_IN_FILTER_CHG_EN
    chk("grp_pulse_count", 32'(pulses_seen), 32'(1));
    chk("grp_mask", 32'(mask_or), 32'h1C0);
`endif
    bus.io_in = 9'h140;
    mask_or = '0;
    repeat (25) cycle();
    chk("grp_io678_held", 32'(bus.io678_out), 32'(1));
`ifdef CON_IN_FILTER_CHG_EN
    chk("grp_drop_mask", 32'(mask_or), 32'h080);
`endif

    // IO1 step interrupted by ENABLE low for 20 cycles.
    apply_reset(2);
    @(negedge CLK);
    bus.io_in = 9'h002;
    repeat (9) cycle();
    bus.enable = 1'b0;
    repeat (20) cycle();
    chk("en_frozen", 32'(bus.io_out), 32'(0));
    bus.enable = 1'b1;
    edges_until(6'h02, 1'b0, 40, e);
    chk("en_latency", 32'(e), 32'(16));

    // Reset mid-count of a new change, then re-acquire all ones.
    bus.io_in = 9'h1FF;
    repeat (30) cycle();
    chk("settled_1ff", 32'(bus.io_out), 32'h3F);
    bus.io_in = 9'h000;
    repeat (8) cycle();
    bus.io_in = 9'h1FF;
    pulses_seen = 0;
    apply_reset(3);
    chk("rst_no_pulse", 32'(pulses_seen), 32'(0));
    edges_until(6'h3F, 1'b1, 40, e);
    chk("reacq_latency", 32'(e), 32'(18));

    // Random phase: held patterns with glitches and occasional ENABLE drops.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) bus.io_in = 9'($urandom);
      else if ($urandom_range(0, 9) == 0) bus.io_in = bus.io_in ^ (9'h1 << $urandom_range(0, 8));
      bus.enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 999) == 0) apply_reset($urandom_range(1, 3));
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
